// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding.
package seq_div_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_div_step.sv
// Single restoring-division step: shift one dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next_c,
    output logic [WIDTH-1:0] q_next_c
);

    logic [WIDTH:0] r_shift;
    logic           ge;

    // Compare/subtract at WIDTH+1 bits; the result always fits back into WIDTH bits.
    always_comb begin
        r_shift  = {r, q[WIDTH-1]};
        ge       = (r_shift >= {1'b0, divisor});
        r_next_c = ge ? WIDTH'(r_shift - {1'b0, divisor}) : r_shift[WIDTH-1:0];
        q_next_c = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and results held until the next completion.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] r_next_c;
    logic [WIDTH-1:0] q_next_c;

    logic accept_c;
    logic dz_c;
    logic step_c;
    logic last_c;
    logic busy_d;
    logic done_d;

    // Partial remainder is stored at WIDTH bits: after every step it is below the divisor.
    seq_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r        (r_q),
        .q        (q_q),
        .divisor  (dvsr_q),
        .r_next_c (r_next_c),
        .q_next_c (q_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start is honoured in DONE as well as IDLE so back-to-back requests lose no cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept_c = start && (state_q != ST_RUN);
        dz_c     = accept_c && (divisor == '0);
        step_c   = (state_q == ST_RUN);
        last_c   = step_c && (cnt_q == '0);
        busy_d   = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
    end

    // Operand capture, iteration registers and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dvsr_q      <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (accept_c) begin
                dvsr_q      <= divisor;
                q_q         <= dividend;
                r_q         <= '0;
                cnt_q       <= CNT_W'(WIDTH - 1);
                div_by_zero <= dz_c;
                if (dz_c) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (step_c) begin
                r_q   <= r_next_c;
                q_q   <= q_next_c;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_c) begin
                    quotient  <= q_next_c;
                    remainder <= r_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (WIDTH=4): latency, results, divide-by-zero,
// ignored starts, mid-run reset, back-to-back starts and a full operand sweep.
module tb_seq_div;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_div #(
        .WIDTH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request, then check latency, busy cycles and results.
    task automatic do_div(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [3:0] exp_q;
        logic [3:0] exp_r;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        do_div("13/4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 5);
        do_div("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
        do_div("0/7", 4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 5);
        do_div("3/9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 5);
        do_div("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5);
        do_div("9/0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
        chk("dz held", 32'(div_by_zero), 32'd1);
        do_div("15/1 after dz", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);

        // New start and operand changes during RUN must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            start = (lat == 2);
            if (lat == 2) begin
                dividend = 4'd7;
                divisor  = 4'd2;
            end
        end
        start = 1'b0;
        chk("ignore latency", 32'(lat), 32'd5);
        chk("ignore quotient", 32'(quotient), 32'd2);
        chk("ignore remainder", 32'(remainder), 32'd2);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("ignore extra done", 32'(pulses), 32'd0);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort no activity", 32'(pulses), 32'd0);
        do_div("6/4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 5);

        // Start held in the DONE cycle is accepted back-to-back.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b first latency", 32'(lat), 32'd5);
        chk("b2b first quotient", 32'(quotient), 32'd2);
        chk("b2b first remainder", 32'(remainder), 32'd1);
        start    = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted busy", 32'(busy), 32'd1);
        chk("b2b accepted done", 32'(done), 32'd0);
        chk("b2b held quotient", 32'(quotient), 32'd2);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b second latency", 32'(lat), 32'd5);
        chk("b2b second quotient", 32'(quotient), 32'd3);
        chk("b2b second remainder", 32'(remainder), 32'd2);

        // Full operand sweep against the arithmetic reference and the invariant.
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                if (dv == 0) begin
                    do_div("sweep dz", 4'(dd), 4'd0, 4'd15, 4'(dd), 1'b1, 1);
                end else begin
                    exp_q = 4'(dd / dv);
                    exp_r = 4'(dd % dv);
                    do_div("sweep", 4'(dd), 4'(dv), exp_q, exp_r, 1'b0, 5);
                    chk("sweep invariant",
                        32'((32'(quotient) * 32'(dv) + 32'(remainder) == 32'(dd)) &&
                            (32'(remainder) < 32'(dv))),
                        32'd1);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
